fsk4_frame_sync: RTL and testbench
==================================

Name: fsk4_frame_sync

Overview:
- Consumes the 4-level hard symbols (+3/+1/-1/-3) produced by the Gardner timing-recovery and decision stage of the FSK demodulator.
- Maps each symbol to a Gray-coded dibit and hunts for a sync word, tolerating a configurable number of bit errors.
- After sync, packs the following payload into bytes and emits them with a one-cycle strobe, plus frame start/done pulses and a lock flag for the board LEDs.

Parameters:
- SYNC_WORD, 16'h1ACF, sync pattern; MSB is received first, 8 symbols long.
- PAYLOAD_BYTES, 16, payload bytes per frame (legal range 1..255).
- MAX_ERR, 1, maximum Hamming distance (in bits) accepted as a sync match.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sym_in  in  8  signed symbol from the decision stage.
- sym_valid  in  1  sym_in is valid this cycle; may be high on consecutive cycles.
- byte_out  out  8  assembled payload byte.
- byte_valid  out  1  one-cycle strobe; byte_out is valid.
- frame_start  out  1  one-cycle pulse when sync is accepted.
- frame_done  out  1  one-cycle pulse coincident with the last payload byte_valid.
- locked  out  1  high while in the PAYLOAD state.
- sym_err  out  1  one-cycle pulse when sym_in is not exactly one of {3, 1, -1, -3}.
- crc_ok  out  1  result of the CRC check (see Optional Feature).
- led  out  8  first payload byte of the last completed frame.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs go to 0 except crc_ok, which goes to 1.
  - State goes to HUNT; shift register, symbol counter and byte counter are cleared.
  - sym_valid is ignored while reset is low.
  - Reset asserted mid-frame abandons the frame; no frame_done is produced.
- Dibit map, applied only when sym_valid is high:
  - sym_in >= 2 gives 01.
  - sym_in of 0 or 1 gives 00.
  - sym_in of -1 or -2 gives 10.
  - sym_in <= -3 gives 11.
  - sym_err pulses on the next cycle if the value is outside {3, 1, -1, -3}; the mapped dibit is still used.
- HUNT state:
  - Each valid symbol shifts its dibit into a 16-bit shift register (new bits enter at the LSB).
  - A hunt counter saturates at 8; it is cleared on entry to HUNT.
  - When the counter has reached 8 and popcount(shift XOR SYNC_WORD) <= MAX_ERR, evaluated on the updated register, the block moves to PAYLOAD.
  - frame_start pulses and locked rises on the cycle after the accepting symbol's sym_valid.
  - The sync symbol itself is never emitted as payload.
- PAYLOAD state:
  - Four valid symbols form one byte, MSB dibit first.
  - byte_valid pulses with byte_out on the cycle after the 4th symbol's sym_valid, giving 1-cycle latency.
  - The byte counter increments on each emitted byte.
  - On byte number PAYLOAD_BYTES:
    - frame_done pulses together with byte_valid, and locked falls the same cycle.
    - led is loaded with the frame's first byte.
    - State returns to HUNT with the hunt counter and shift register cleared, so back-to-back frames need a fresh sync.
- Counters do not wrap; the byte counter is 8 bits wide and compared for equality only.
- Cycles without sym_valid hold all state; strobes are only 1 cycle wide.
- Outputs are fully registered; there is no combinational path from sym_in to any output.

Optional Feature:
- Macro: FSK4_FRAME_CRC8_CHECK_EN.
- When defined:
  - The last payload byte is treated as CRC-8 (polynomial 0x07, init 0x00, MSB-first, no reflection) over bytes 1..PAYLOAD_BYTES-1.
  - The CRC is updated on each byte_valid.
  - At frame_done, crc_ok is registered as (computed CRC == last byte) and held until the next frame_done or reset.
  - led is loaded only if the CRC matches; otherwise it keeps its old value.
  - The CRC byte is still output on byte_out.
- When not defined:
  - crc_ok is tied to 1, no CRC logic is synthesised, and led loads on every frame_done.

Test Plan:
- Reset state: hold reset low, drive random sym_valid/sym_in -> all outputs 0, crc_ok 1; release reset, no strobes until a sync is sent.
- Clean frame, default parameters: send 8 sync symbols for 16'h1ACF, then 64 payload symbols with the first 4 = -1,-1,+3,+3 (0xA5) -> frame_start 1 cycle after the 8th sync symbol; 16 byte_valid strobes, first = 0xA5; frame_done with the 16th; led = 0xA5; locked high only between those events.
- Error tolerance, MAX_ERR=1: sync with 1 flipped bit -> lock achieved; sync with 2 flipped bits -> no frame_start, block stays in HUNT.
- Non-ideal symbols and gaps: symbols 2, 0, -2, -4 with random idle cycles between sym_valid -> byte 0x4B emitted; sym_err pulses 4 times; no strobe during idle cycles.
- Reset mid-frame: assert reset after 5 payload bytes -> no frame_done; after release, a new full frame decodes correctly.
- CRC, macro defined, PAYLOAD_BYTES=4: payload 0x01,0x02,0x03 plus correct CRC 0x48 -> crc_ok 1, led 0x01; same frame with a wrong CRC byte -> crc_ok 0, led unchanged.

Source files
------------

// File: rtl/fsk4_frame_sync.sv
// Frame synchroniser for 4-FSK hard symbols: dibit mapping, error-tolerant sync hunt, payload byte packing.
// Optional CRC-8 check of the last payload byte is enabled by defining FSK4_FRAME_CRC8_CHECK_EN.
module fsk4_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'h1ACF,
  parameter int          PAYLOAD_BYTES = 16,
  parameter int          MAX_ERR       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] sym_in,
  input  logic              sym_valid,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              locked,
  output logic              sym_err,
  output logic              crc_ok,
  output logic [7:0]        led
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES);
  localparam logic [4:0] ERR_LIMIT = 5'(MAX_ERR);
  localparam logic [3:0] SYNC_SYMS = 4'd8;

  typedef enum logic {HUNT, PAYLOAD} state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(v[i]);
    return cnt;
  endfunction

`ifdef FSK4_FRAME_CRC8_CHECK_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] v);
    logic [7:0] c;
    c = v;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  hunt_cnt_q, hunt_cnt_d;
  logic [1:0]  sym_cnt_q, sym_cnt_d;
  logic [5:0]  byte_sr_q, byte_sr_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  first_byte_q, first_byte_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        locked_q, locked_d;
  logic        sym_err_q, sym_err_d;
  logic [7:0]  led_q, led_d;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
  logic [7:0]  crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;
`endif

  logic [1:0]  dibit;
  logic        sym_bad;
  logic [15:0] shift_next;
  logic [3:0]  hunt_cnt_next;
  logic        sync_hit;
  logic [7:0]  byte_new;
  logic [7:0]  byte_cnt_inc;
  logic [7:0]  led_src;

  // Slicer thresholds sit midway between the ideal levels, so off-grid values still map
  always_comb begin
    if (sym_in >= 8'sd2)       dibit = 2'b01;
    else if (sym_in >= 8'sd0)  dibit = 2'b00;
    else if (sym_in >= -8'sd2) dibit = 2'b10;
    else                       dibit = 2'b11;
    sym_bad = !((sym_in == 8'sd3) || (sym_in == 8'sd1) ||
                (sym_in == -8'sd1) || (sym_in == -8'sd3));
    shift_next    = {shift_q[13:0], dibit};
    hunt_cnt_next = (hunt_cnt_q == SYNC_SYMS) ? hunt_cnt_q : hunt_cnt_q + 4'd1;
    sync_hit      = popcount16(shift_next ^ SYNC_WORD) <= ERR_LIMIT;
    byte_new      = {byte_sr_q, dibit};
    byte_cnt_inc  = byte_cnt_q + 8'd1;
    led_src       = (byte_cnt_q == 8'd0) ? byte_new : first_byte_q;
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    hunt_cnt_d    = hunt_cnt_q;
    sym_cnt_d     = sym_cnt_q;
    byte_sr_d     = byte_sr_q;
    byte_cnt_d    = byte_cnt_q;
    first_byte_d  = first_byte_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    locked_d      = locked_q;
    sym_err_d     = 1'b0;
    led_d         = led_q;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
    crc_d         = crc_q;
    crc_ok_d      = crc_ok_q;
`endif
    if (sym_valid) begin
      sym_err_d = sym_bad;
      case (state_q)
        HUNT: begin
          shift_d    = shift_next;
          hunt_cnt_d = hunt_cnt_next;
          if ((hunt_cnt_next == SYNC_SYMS) && sync_hit) begin
            state_d       = PAYLOAD;
            frame_start_d = 1'b1;
            locked_d      = 1'b1;
            sym_cnt_d     = 2'd0;
            byte_cnt_d    = 8'd0;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
            crc_d         = 8'd0;
`endif
          end
        end
        PAYLOAD: begin
          sym_cnt_d = sym_cnt_q + 2'd1;
          byte_sr_d = byte_new[5:0];
          if (sym_cnt_q == 2'd3) begin
            byte_out_d   = byte_new;
            byte_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_inc;
            if (byte_cnt_q == 8'd0) first_byte_d = byte_new;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
            crc_d = crc8_byte(crc_q ^ byte_new);
`endif
            // Last byte closes the frame and forces a fresh 8-symbol hunt
            if (byte_cnt_inc == LAST_BYTE) begin
              frame_done_d = 1'b1;
              locked_d     = 1'b0;
              state_d      = HUNT;
              hunt_cnt_d   = 4'd0;
              shift_d      = 16'd0;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
              crc_ok_d = (crc_q == byte_new);
              if (crc_q == byte_new) led_d = led_src;
`else
              led_d = led_src;
`endif
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HUNT;
      shift_q       <= 16'd0;
      hunt_cnt_q    <= 4'd0;
      sym_cnt_q     <= 2'd0;
      byte_sr_q     <= 6'd0;
      byte_cnt_q    <= 8'd0;
      first_byte_q  <= 8'd0;
      byte_out_q    <= 8'd0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      sym_err_q     <= 1'b0;
      led_q         <= 8'd0;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
      crc_q         <= 8'd0;
      crc_ok_q      <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      hunt_cnt_q    <= hunt_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      byte_sr_q     <= byte_sr_d;
      byte_cnt_q    <= byte_cnt_d;
      first_byte_q  <= first_byte_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      locked_q      <= locked_d;
      sym_err_q     <= sym_err_d;
      led_q         <= led_d;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
      crc_q         <= crc_d;
      crc_ok_q      <= crc_ok_d;
`endif
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign sym_err     = sym_err_q;
  assign led         = led_q;
`ifdef FSK4_FRAME_CRC8_CHECK_EN
  assign crc_ok      = crc_ok_q;
`else
  assign crc_ok      = 1'b1;
`endif

endmodule

// File: tb/tb_fsk4_frame_sync.sv
// Directed bench for fsk4_frame_sync; payload length shrinks to 4 bytes when FSK4_FRAME_CRC8_CHECK_EN is defined.
module tb_fsk4_frame_sync;

`ifdef FSK4_FRAME_CRC8_CHECK_EN
  localparam int PB = 4;
`else
  localparam int PB = 16;
`endif
  localparam int MID = (PB > 5) ? 5 : PB - 1;
  localparam logic [15:0] SYNC = 16'h1ACF;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] sym_in;
  logic              sym_valid;
  logic [7:0]        byte_out;
  logic              byte_valid, frame_start, frame_done, locked, sym_err, crc_ok;
  logic [7:0]        led;

  int errors = 0;
  int checks = 0;
  int n_bv = 0, n_fs = 0, n_fd = 0, n_se = 0, n_lk = 0;
  logic [7:0] bytes_q[$];
  logic [7:0] frame_buf[256];

  fsk4_frame_sync #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB), .MAX_ERR(1)) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_done(frame_done), .locked(locked), .sym_err(sym_err),
    .crc_ok(crc_ok), .led(led)
  );

  always #5 clk = ~clk;

  // Event monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      bytes_q.push_back(byte_out);
    end
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (sym_err)     n_se++;
    if (locked)      n_lk++;
  end

  function automatic logic signed [7:0] dibit_sym(input logic [1:0] d);
    case (d)
      2'b01:   return 8'sd3;
      2'b00:   return 8'sd1;
      2'b10:   return -8'sd1;
      default: return -8'sd3;
    endcase
  endfunction

  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic idle(input int n);
    sym_valid = 1'b0;
    sym_in = 8'sd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sym(input logic signed [7:0] s);
    sym_in = s;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_sym(dibit_sym(b[2*i +: 2]));
  endtask

  task automatic send_sync(input logic [15:0] w);
    for (int i = 7; i >= 0; i--) send_sym(dibit_sym(w[2*i +: 2]));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic build_frame(input logic [7:0] first);
    logic [7:0] c;
    frame_buf[0] = first;
    for (int i = 1; i < PB; i++) frame_buf[i] = 8'(i * 37 + 11);
`ifdef FSK4_FRAME_CRC8_CHECK_EN
    c = 8'h00;
    for (int i = 0; i < PB - 1; i++) c = crc_model(c, frame_buf[i]);
    frame_buf[PB-1] = c;
`else
    c = 8'h00;
`endif
  endtask

  task automatic test_reset();
    int bv0, fs0, fd0;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sym_valid = 1'($urandom_range(0, 1));
      sym_in = 8'($urandom);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    checks++;
    if ({byte_out, byte_valid, frame_start, frame_done, locked, sym_err, led} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {byte_out, byte_valid, frame_start, frame_done, locked, sym_err, led});
    end
    checks++;
    if (crc_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_crc_ok: got %b required 1", crc_ok);
    end
    bv0 = n_bv; fs0 = n_fs; fd0 = n_fd;
    reset = 1'b1;
    idle(6);
    checks++;
    if ((n_bv - bv0) + (n_fs - fs0) + (n_fd - fd0) !== 0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_quiet: strobes %0d locked %b required 0 and 0", (n_bv - bv0) + (n_fs - fs0) + (n_fd - fd0), locked);
    end
  endtask

  // Sends one full frame from frame_buf after a clean sync and checks every framing event
  task automatic run_frame(input string tag, input logic [7:0] first);
    int bv0, fs0, fd0, lk0, base, bad;
    build_frame(first);
    bv0 = n_bv; fs0 = n_fs; fd0 = n_fd; lk0 = n_lk; base = bytes_q.size();
    send_sync(SYNC);
    checks++;
    if (frame_start !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_frame_start: got fs=%b locked=%b required 1 1", tag, frame_start, locked);
    end
    for (int i = 0; i < PB; i++) send_byte(frame_buf[i]);
    checks++;
    if (frame_done !== 1'b1 || byte_valid !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_frame_done: got fd=%b bv=%b locked=%b required 1 1 0", tag, frame_done, byte_valid, locked);
    end
    idle(2);
    checks++;
    if (n_bv - bv0 !== PB || n_fs - fs0 !== 1 || n_fd - fd0 !== 1) begin
      errors++;
      $display("[TB] FAIL %s_counts: got bv=%0d fs=%0d fd=%0d required %0d 1 1", tag, n_bv - bv0, n_fs - fs0, n_fd - fd0, PB);
    end
    bad = 0;
    for (int i = 0; i < PB; i++)
      if (base + i >= bytes_q.size() || bytes_q[base + i] !== frame_buf[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL %s_bytes: got %0d wrong bytes required 0", tag, bad);
    end
    checks++;
    if (led !== first) begin
      errors++;
      $display("[TB] FAIL %s_led: got %h required %h", tag, led, first);
    end
    checks++;
    if (n_lk - lk0 !== 4 * PB) begin
      errors++;
      $display("[TB] FAIL %s_locked_span: got %0d cycles required %0d", tag, n_lk - lk0, 4 * PB);
    end
    checks++;
    if (crc_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_crc_ok: got %b required 1", tag, crc_ok);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    run_frame("clean", 8'hA5);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b", 8'h3C);
  endtask

  task automatic test_err_tolerance();
    int fs0;
    do_reset();
    send_sync(SYNC ^ 16'h0100);
    checks++;
    if (frame_start !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err1_lock: got fs=%b locked=%b required 1 1", frame_start, locked);
    end
    do_reset();
    fs0 = n_fs;
    send_sync(SYNC ^ 16'h4001);
    idle(3);
    checks++;
    if (n_fs - fs0 !== 0 || locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err2_reject: got fs=%0d locked=%b required 0 0", n_fs - fs0, locked);
    end
  endtask

  task automatic test_nonideal();
    int bv0, se0;
    do_reset();
    send_sync(SYNC);
    bv0 = n_bv; se0 = n_se;
    send_sym(8'sd2);
    checks++;
    if (sym_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonideal_sym_err_pulse: got %b required 1", sym_err);
    end
    idle(2);
    checks++;
    if (sym_err !== 1'b0 || byte_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nonideal_idle: got se=%b bv=%b required 0 0", sym_err, byte_valid);
    end
    send_sym(8'sd0);
    idle(1);
    send_sym(-8'sd2);
    idle(3);
    send_sym(-8'sd4);
    checks++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL nonideal_byte: got bv=%b byte=%h required 1 4b", byte_valid, byte_out);
    end
    idle(2);
    checks++;
    if (n_se - se0 !== 4 || n_bv - bv0 !== 1) begin
      errors++;
      $display("[TB] FAIL nonideal_counts: got se=%0d bv=%0d required 4 1", n_se - se0, n_bv - bv0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    do_reset();
    build_frame(8'h77);
    send_sync(SYNC);
    for (int i = 0; i < MID; i++) send_byte(frame_buf[i]);
    fd0 = n_fd;
    reset = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || byte_out !== 8'h00 || crc_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_async: got locked=%b byte=%h crc_ok=%b required 0 00 1", locked, byte_out, crc_ok);
    end
    idle(3);
    reset = 1'b1;
    idle(2);
    checks++;
    if (n_fd - fd0 !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: got %0d frame_done required 0", n_fd - fd0);
    end
    run_frame("after_reset", 8'h5A);
  endtask

`ifdef FSK4_FRAME_CRC8_CHECK_EN
  task automatic test_crc();
    do_reset();
    send_sync(SYNC);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h48);
    checks++;
    if (frame_done !== 1'b1 || crc_ok !== 1'b1 || led !== 8'h01) begin
      errors++;
      $display("[TB] FAIL crc_good: got fd=%b crc_ok=%b led=%h required 1 1 01", frame_done, crc_ok, led);
    end
    send_sync(SYNC);
    send_byte(8'h09); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    checks++;
    if (frame_done !== 1'b1 || crc_ok !== 1'b0 || led !== 8'h01 || byte_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL crc_bad: got fd=%b crc_ok=%b led=%h byte=%h required 1 0 01 00", frame_done, crc_ok, led, byte_out);
    end
    idle(3);
    checks++;
    if (crc_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL crc_hold: got %b required 0", crc_ok);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    sym_valid = 1'b0;
    sym_in = 8'sd0;
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_err_tolerance();
    test_nonideal();
    test_reset_mid_frame();
`ifdef FSK4_FRAME_CRC8_CHECK_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
